spi_master_fifo: RTL and testbench
==================================

# spi_master_fifo

Byte-stream SPI initiator that drives the opposite end of the `SPI_slave_full` link. It takes bytes from a small transmit FIFO, frames each one with a one-cycle `ss` start strobe, and shifts it MSB-first on `mosi`. In the same frame it captures the returned byte from `miso` and presents it on `rx_data` with a one-cycle `rx_valid` pulse. The block shares the bus clock `sclk` with the slave, and every bus signal it drives is a register output.

## Interface
- `WIDTH`, 8: bits per frame.
- `DEPTH`, 4: transmit FIFO entries; power of two, ≥2.
- `sclk` in 1: single clock, all logic on posedge.
- `rst_L` in 1: reset, asynchronous assert, active-low.
- `tx_data` in WIDTH: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: FIFO can accept; a push occurs on a posedge with `tx_valid && tx_ready`.
- `ss` out 1: frame-start strobe, active-high, exactly one cycle per frame.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.
- `rx_data` out WIDTH: last received byte, held until the next frame completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: a frame is in progress.

## Operation
- **Transmit FIFO**
  - DEPTH entries; write/read pointers one bit wider than the address, for full/empty detection.
  - `tx_ready = !full`, combinational from registered pointers; it does not look ahead at a same-cycle pop.
  - Push and pop may occur on the same posedge; the count stays unchanged.
- **State machine**
  - States IDLE and SHIFT; bit counter `cnt`, 0..WIDTH-1.
  - **IDLE**
    - If FIFO not empty at a posedge: pop head into `tx_shift`, `ss<=1`, `mosi<=head[WIDTH-1]`, `cnt<=0`, go to SHIFT.
    - Otherwise: `ss=0`, `mosi=0`.
  - **SHIFT, each posedge:**
    - Sample `miso` into `rx_shift` (MSB first).
    - `ss<=0`.
  - **SHIFT, `cnt<WIDTH-1`:**
    - `cnt<=cnt+1`.
    - `mosi<=` next lower bit of `tx_shift`.
  - **SHIFT, `cnt==WIDTH-1` (last bit):**
    - `rx_data<={rx_shift[WIDTH-2:0],miso}`, `rx_valid<=1`.
    - If FIFO not empty: pop and start the next frame on the same edge (`ss<=1`, `cnt<=0`, new MSB on `mosi`). Frames run back-to-back with no gap.
    - Else: go to IDLE, `mosi<=0`.
- **`busy`:** registered; 1 in SHIFT.
- **`rx_valid`:** cleared on every posedge where it is not set.
- **Bit order:** MSB first. Bit WIDTH-1 is on `mosi` during the `ss`-high cycle; bit 0 is in the WIDTH-th cycle of the frame.

## Timing
- **Reset values:** `ss=0`, `mosi=0`, `rx_data=0`, `rx_valid=0`, `busy=0`, `tx_ready=1`; FIFO empty; state IDLE; `cnt=0`.
- **Frame length:** exactly WIDTH cycles, `ss` high in the first cycle only.
- **Latency:**
  - Push on posedge P into an empty, idle block → `ss` and MSB valid from posedge P+1.
  - `rx_valid` is high in the cycle after the frame's last bit cycle, i.e. starting at posedge P+1+WIDTH.
- **Sampling:** `miso` is sampled on the posedge that ends each bit cycle. With `miso` tied to `mosi`, `rx_data` equals the sent byte.
- **Back-to-back frames:** `rx_valid` of frame k coincides with the `ss` of frame k+1.
- **FIFO boundaries:**
  - Full: `tx_valid` is ignored; no overwrite.
  - Pop when empty: never occurs.
- **Reset mid-frame:** all outputs return to their reset values immediately; the FIFO is flushed; no `rx_valid` is produced for the aborted frame.
- **`tx_data` stability:** not required after the push edge.

## Test plan
- **Reset:** assert `rst_L=0` mid-stream → `ss=0`, `mosi=0`, `busy=0`, `rx_valid=0`, `tx_ready=1` while asserted and on release; no frame starts afterward.
- **Single-byte loopback:** `miso=mosi`, push 8'hA5 → `ss` high 1 cycle, `mosi` sequence 1,0,1,0,0,1,0,1; `rx_data=8'hA5` with `rx_valid` 8 cycles after `ss`.
- **Back-to-back loopback:** push A5,5A,AA,CC,0F,F0 (same set the slave bench uses) → six consecutive 8-cycle frames with no gap; `ss` every 8th cycle; `rx_data` matches each byte in order.
- **FIFO full:** hold `miso=0`, push 6 bytes without waiting → `tx_ready` drops after 4+1 accepted bytes (one byte popped into shift). Extra `tx_valid` is dropped; exactly 5 frames are sent.
- **Simultaneous events:** push on the same posedge as a last-bit pop with the FIFO at DEPTH-1 → count unchanged, no loss, order preserved.
- **Reset mid-frame:** reset at bit 3 of 8'hCC → no `rx_valid`; after release, push 8'h0F → clean frame, `rx_data=8'h0F` (loopback).

Source files
------------

// File: rtl/spi_master_fifo.sv
// SPI initiator fed by a small transmit FIFO: one-cycle ss start strobe, MSB-first
// shift on mosi, full-duplex capture from miso with a one-cycle rx_valid pulse.
module spi_master_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             sclk,
   input  logic             rst_L,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             ss,
   output logic             mosi,
   input  logic             miso,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [WIDTH-1:0] fifo_mem [DEPTH];
   logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
   logic             full, empty, push, pop;
   logic [WIDTH-1:0] head;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   // The MSB goes straight from the FIFO head to mosi, so only the lower bits are kept.
   logic [WIDTH-2:0] tx_shift_reg, tx_shift_next;
   logic [WIDTH-2:0] rx_shift_reg, rx_shift_next;
   logic [WIDTH-1:0] rx_full;
   logic             ss_reg, ss_next;
   logic             mosi_reg, mosi_next;
   logic [WIDTH-1:0] rx_data_reg, rx_data_next;
   logic             rx_valid_reg, rx_valid_next;
   logic             busy_reg, busy_next;

   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign tx_ready = !full;
   assign push     = tx_valid && !full;
   assign head     = fifo_mem[rd_ptr_reg[AW-1:0]];
   assign rx_full  = {rx_shift_reg, miso};

   always_ff @(posedge sclk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg[AW-1:0]] <= tx_data;
      end
   end

   always_ff @(posedge sclk or negedge rst_L) begin
      if (!rst_L) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
         if (pop)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      tx_shift_next = tx_shift_reg;
      rx_shift_next = rx_shift_reg;
      ss_next       = 1'b0;
      mosi_next     = mosi_reg;
      rx_data_next  = rx_data_reg;
      rx_valid_next = 1'b0;
      pop           = 1'b0;
      case (state_reg)
         IDLE: begin
            mosi_next = 1'b0;
            if (!empty) begin
               pop           = 1'b1;
               tx_shift_next = head[WIDTH-2:0];
               ss_next       = 1'b1;
               mosi_next     = head[WIDTH-1];
               cnt_next      = '0;
               state_next    = SHIFT;
            end
         end
         SHIFT: begin
            rx_shift_next = rx_full[WIDTH-2:0];
            if (cnt_reg != LAST_BIT) begin
               cnt_next      = cnt_reg + CW'(1);
               mosi_next     = tx_shift_reg[WIDTH-2];
               tx_shift_next = tx_shift_reg << 1;
            end else begin
               rx_data_next  = rx_full;
               rx_valid_next = 1'b1;
               // Chain straight into the next frame so frames run with no idle gap.
               if (!empty) begin
                  pop           = 1'b1;
                  tx_shift_next = head[WIDTH-2:0];
                  ss_next       = 1'b1;
                  mosi_next     = head[WIDTH-1];
                  cnt_next      = '0;
               end else begin
                  mosi_next  = 1'b0;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next == SHIFT);
   end

   always_ff @(posedge sclk or negedge rst_L) begin
      if (!rst_L) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         tx_shift_reg <= '0;
         rx_shift_reg <= '0;
         ss_reg       <= 1'b0;
         mosi_reg     <= 1'b0;
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         tx_shift_reg <= tx_shift_next;
         rx_shift_reg <= rx_shift_next;
         ss_reg       <= ss_next;
         mosi_reg     <= mosi_next;
         rx_data_reg  <= rx_data_next;
         rx_valid_reg <= rx_valid_next;
         busy_reg     <= busy_next;
      end
   end

   assign ss       = ss_reg;
   assign mosi     = mosi_reg;
   assign rx_data  = rx_data_reg;
   assign rx_valid = rx_valid_reg;
   assign busy     = busy_reg;

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: loopback frames, back-to-back streaming,
// FIFO-full dropping, simultaneous push/pop and reset in the middle of a frame.
module tb_spi_master_fifo;

   logic       sclk;
   logic       rst_L;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ss;
   logic       mosi;
   logic       miso;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;

   logic       loop_en;
   logic       miso_force;

   int checks = 0;
   int errors = 0;

   spi_master_fifo #(.WIDTH(8), .DEPTH(4)) dut (
      .sclk     (sclk),
      .rst_L    (rst_L),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .ss       (ss),
      .mosi     (mosi),
      .miso     (miso),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy)
   );

   assign miso = loop_en ? mosi : miso_force;

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the byte is pushed on the following posedge.
   task automatic push1(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge sclk);
      tx_valid = 1'b0;
   endtask

   // Waits up to budget cycles for ss, checks the 8-bit mosi pattern, then the rx result.
   task automatic frame(input logic [7:0] etx, input logic [7:0] erx, input int budget);
      int n = 0;
      logic [7:0] bits;
      while (ss !== 1'b1 && n < budget) begin
         @(negedge sclk);
         n++;
      end
      check("frame_start", ss, 1);
      if (ss !== 1'b1) return;
      check("busy_in_frame", busy, 1);
      bits[7] = mosi;
      for (int k = 6; k >= 0; k--) begin
         @(negedge sclk);
         check("ss_one_cycle", ss, 0);
         bits[k] = mosi;
      end
      check("mosi_bits", bits, etx);
      @(negedge sclk);
      check("rx_valid", rx_valid, 1);
      check("rx_data", rx_data, erx);
   endtask

   logic [7:0] b2b   [6] = '{8'hA5, 8'h5A, 8'hAA, 8'hCC, 8'h0F, 8'hF0};
   logic [7:0] fullb [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
   logic [7:0] simb  [5] = '{8'h3C, 8'h81, 8'h7E, 8'h96, 8'h69};

   initial begin
      int wt;
      int seen;
      int rvs;

      rst_L      = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      loop_en    = 1'b1;
      miso_force = 1'b0;

      // Reset state
      repeat (2) @(negedge sclk);
      check("rst_ss", ss, 0);
      check("rst_mosi", mosi, 0);
      check("rst_busy", busy, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_data", rx_data, 8'h00);
      rst_L = 1'b1;
      repeat (2) @(negedge sclk);
      check("idle_no_ss", ss, 0);

      // Single-byte loopback
      push1(8'hA5);
      frame(8'hA5, 8'hA5, 10);
      check("mosi_idle", mosi, 0);
      @(negedge sclk);
      check("rx_valid_pulse", rx_valid, 0);
      check("busy_idle", busy, 0);
      check("rx_data_hold", rx_data, 8'hA5);
      repeat (3) @(negedge sclk);

      // Back-to-back loopback
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               tx_data  = b2b[i];
               tx_valid = 1'b1;
               wt = 0;
               while (!tx_ready && wt < 50) begin
                  @(negedge sclk);
                  wt++;
               end
               @(negedge sclk);
            end
            tx_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 6; i++) frame(b2b[i], b2b[i], (i == 0) ? 10 : 0);
         end
      join
      @(negedge sclk);
      check("b2b_done_busy", busy, 0);
      repeat (3) @(negedge sclk);

      // FIFO full: six pushes on consecutive edges, only five accepted
      loop_en    = 1'b0;
      miso_force = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               tx_data  = fullb[i];
               tx_valid = 1'b1;
               @(negedge sclk);
               check("tx_ready_fill", tx_ready, (i < 4) ? 1 : 0);
            end
            tx_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 5; i++) frame(fullb[i], 8'h00, (i == 0) ? 10 : 0);
         end
      join
      seen = 0;
      repeat (20) begin
         @(negedge sclk);
         if (ss === 1'b1) seen++;
      end
      check("full_no_sixth_frame", seen, 0);
      check("full_tx_ready_back", tx_ready, 1);
      check("full_busy_idle", busy, 0);

      // Push on the same edge as a last-bit pop with the FIFO at DEPTH-1
      loop_en = 1'b1;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               tx_data  = simb[i];
               tx_valid = 1'b1;
               @(negedge sclk);
            end
            tx_valid = 1'b0;
            repeat (5) @(negedge sclk);
            tx_data  = simb[4];
            tx_valid = 1'b1;
            @(negedge sclk);
            tx_valid = 1'b0;
            check("simul_tx_ready", tx_ready, 1);
         end
         begin
            for (int i = 0; i < 5; i++) frame(simb[i], simb[i], (i == 0) ? 10 : 0);
         end
      join
      repeat (3) @(negedge sclk);

      // Reset in the middle of a frame (during bit 3 of 8'hCC)
      push1(8'hCC);
      wt = 0;
      while (ss !== 1'b1 && wt < 10) begin
         @(negedge sclk);
         wt++;
      end
      check("cc_start", ss, 1);
      repeat (4) @(negedge sclk);
      check("cc_bit3", mosi, 1);
      rst_L = 1'b0;
      #1;
      check("midrst_ss", ss, 0);
      check("midrst_mosi", mosi, 0);
      check("midrst_busy", busy, 0);
      check("midrst_rx_valid", rx_valid, 0);
      check("midrst_tx_ready", tx_ready, 1);
      check("midrst_rx_data", rx_data, 8'h00);
      repeat (2) @(negedge sclk);
      check("midrst_hold_busy", busy, 0);
      check("midrst_hold_ss", ss, 0);
      rst_L = 1'b1;
      seen = 0;
      rvs  = 0;
      repeat (15) begin
         @(negedge sclk);
         if (ss === 1'b1) seen++;
         if (rx_valid === 1'b1) rvs++;
      end
      check("postrst_no_frame", seen, 0);
      check("postrst_no_rx_valid", rvs, 0);
      check("postrst_mosi", mosi, 0);
      push1(8'h0F);
      frame(8'h0F, 8'h0F, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
